mont_mul_arbiter: RTL and testbench
===================================

Name: mont_mul_arbiter

Overview:
- Shares one Montgomery multiplier between N_REQ requesters, e.g. the multiply and square paths of the RSA exponentiation core, or two RSA core instances.
- Each requester raises a level request with operands. The arbiter grants round-robin, latches the operands and issues a one-cycle start to the multiplier.
- It waits for the multiplier's done, then returns the product to the granted requester with a one-cycle done pulse.
- The block only sequences and routes operands and results; it performs no arithmetic.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- WIDTH, 256, operand/result width in bits.
- TIMEOUT, 1023, watchdog limit in cycles. Used only with MONT_ARB_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset, synchronous, active-low (0 = reset).
- i_req  in  N_REQ  level request per requester; held until that requester's o_done.
- i_req_a  in  N_REQ*WIDTH  operand a; requester k occupies [k*WIDTH +: WIDTH].
- i_req_b  in  N_REQ*WIDTH  operand b, same packing.
- i_req_n  in  N_REQ*WIDTH  modulus, same packing.
- o_grant  out  N_REQ  one-hot owner of the multiplier; 0 when idle.
- o_done  out  N_REQ  one-cycle pulse to the owner when its result is valid.
- o_result  out  WIDTH  product; valid only while any o_done bit is 1.
- o_busy  out  1  1 in every state except S_IDLE.
- o_mul_start  out  1  one-cycle start pulse to the multiplier.
- o_mul_a, o_mul_b, o_mul_n  out  WIDTH  registered operands; stable from S_ISSUE until S_IDLE.
- i_mul_done  in  1  multiplier completion pulse.
- i_mul_result  in  WIDTH  multiplier result; sampled when i_mul_done is 1.
- o_error  out  1  timeout pulse. Present only with MONT_ARB_TIMEOUT_EN.

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - state = S_IDLE, round-robin pointer = 0.
  - o_grant, o_done, o_mul_start, o_busy, o_error = 0.
  - o_result, o_mul_a/b/n = 0.
  - Reset mid-operation abandons the transaction. The multiplier shares this reset.
- States: S_IDLE -> S_ISSUE -> S_WAIT -> S_RESP -> S_IDLE.
- S_IDLE:
  - If any i_req bit is set, select the first set bit searching upward from the pointer, wrapping modulo N_REQ.
  - Register the grant one-hot and latch that requester's a/b/n into o_mul_a/b/n. Go to S_ISSUE.
  - If no request, stay in S_IDLE.
- S_ISSUE: o_mul_start=1 for exactly this cycle, then go to S_WAIT.
- S_WAIT:
  - On i_mul_done=1, latch i_mul_result into o_result and go to S_RESP.
  - Otherwise stay in S_WAIT.
  - i_mul_done is ignored in every other state.
- S_RESP:
  - o_done[grant]=1 for one cycle.
  - pointer <= (granted index + 1) mod N_REQ.
  - Clear o_grant when leaving S_RESP. Go to S_IDLE.
- Latency:
  - Request sampled in S_IDLE at cycle 0; o_mul_start at cycle 1.
  - With i_mul_done at cycle D (D >= 2), o_done at cycle D+1.
  - The next grant is issued no earlier than cycle D+2, so there is one idle cycle between transactions.
- Requester rule: drop i_req in the cycle after seeing o_done, or raise it again with new operands.
  - A request still high in S_IDLE is a new request.
  - Because the pointer has advanced, any other pending requester wins first. This prevents starvation.
- i_req changes while the requester is granted have no effect; operands are latched.
- Deasserting i_req while granted does not cancel the transaction; o_done is still produced.
- Simultaneous requests are resolved by the pointer only.

Optional Feature:
- MONT_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to S_WAIT and increments each cycle in S_WAIT.
  - If it reaches TIMEOUT without i_mul_done, go to S_IDLE and pulse o_error for one cycle.
  - No o_done is issued and o_result is unchanged. The pointer advances past the granted requester.
- MONT_ARB_TIMEOUT_EN undefined: no counter and no o_error port; S_WAIT waits indefinitely.

Test Plan:
- Reset check: drive i_rst=0 for 3 cycles with i_req=2'b11 -> o_grant=0, o_busy=0, o_mul_start=0, all outputs 0.
- Single requester, bench multiplier with 5-cycle latency returning 32'h1234:
  - Stimulus: req0 with a=3, b=5, n=7.
  - Expect o_grant=01, o_mul_a/b/n = 3/5/7, o_mul_start at cycle 1.
  - Expect o_done=01 with o_result=32'h1234 at cycle 7, o_busy low at cycle 8.
- Simultaneous requests i_req=11 held:
  - Grants go 01, 10, 01.
  - Each o_mul_start pulses exactly once per grant.
  - o_done reaches the matching requester only.
- Operand stability: change i_req_a of the granted requester during S_WAIT -> o_mul_a holds the latched value; result is unaffected.
- Spurious i_mul_done asserted in S_IDLE and in S_ISSUE -> ignored; no o_done, state advances normally.
- With MONT_ARB_TIMEOUT_EN and TIMEOUT=8, multiplier never signals done:
  - Expect o_error pulse exactly 8 cycles after entering S_WAIT, o_done=0, then S_IDLE.
  - A pending req1 is granted next.

Source files
------------

// File: rtl/mont_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mont_mul_arbiter
//  Description : Round-robin arbiter that shares one Montgomery multiplier
//                between N_REQ requesters. Latches the winner's operands,
//                pulses the multiplier start, waits for its done and routes
//                the product back with a one-cycle done pulse.
//                Optional watchdog: define MONT_ARB_TIMEOUT_EN to abandon a
//                transaction after TIMEOUT cycles in S_WAIT (adds o_error).
//  Revision    : 1.0 - initial release
// ============================================================================
module mont_mul_arbiter #(
    parameter int N_REQ   = 2,
    parameter int WIDTH   = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*WIDTH-1:0] i_req_a,
    input  logic [N_REQ*WIDTH-1:0] i_req_b,
    input  logic [N_REQ*WIDTH-1:0] i_req_n,
    output logic [N_REQ-1:0]       o_grant,
    output logic [N_REQ-1:0]       o_done,
    output logic [WIDTH-1:0]       o_result,
    output logic                   o_busy,
    output logic                   o_mul_start,
    output logic [WIDTH-1:0]       o_mul_a,
    output logic [WIDTH-1:0]       o_mul_b,
    output logic [WIDTH-1:0]       o_mul_n,
    input  logic                   i_mul_done,
    input  logic [WIDTH-1:0]       i_mul_result
`ifdef MONT_ARB_TIMEOUT_EN
    ,
    output logic                   o_error
`endif
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_gidx;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [PTR_W-1:0]   w_sel_idx;
    logic               w_sel_vld;
    logic [PTR_W:0]     w_scan;

    logic [N_REQ-1:0]   r_grant;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic [WIDTH-1:0]   r_mul_n;
    logic [WIDTH-1:0]   r_result;

    logic               w_timeout;

    // Elaboration-time sanity check of the configuration
    generate
        if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
            $error("mont_mul_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
        end
    endgenerate

    // Round-robin search: first set request at or above the pointer, wrapping
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        w_scan    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_scan = {1'b0, r_ptr} + (PTR_W+1)'(i);
            if (w_scan >= (PTR_W+1)'(N_REQ)) begin
                w_scan = w_scan - (PTR_W+1)'(N_REQ);
            end
            if (!w_sel_vld && i_req[w_scan[PTR_W-1:0]]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = w_scan[PTR_W-1:0];
            end
        end
    end

    // Pointer value that places the just-served requester last in priority
    assign w_ptr_nxt = (r_gidx == PTR_W'(N_REQ-1)) ? '0 : r_gidx + PTR_W'(1);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        o_mul_start = 1'b0;
        o_busy      = 1'b1;
        o_done      = '0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (w_sel_vld) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_mul_start = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Completion takes precedence over a watchdog expiring the same cycle
                if (i_mul_done) begin
                    w_state_nxt = S_RESP;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RESP: begin
                o_done      = r_grant;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant, operand, result and pointer registers
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ptr    <= '0;
            r_gidx   <= '0;
            r_grant  <= '0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_mul_n  <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel_vld) begin
                        r_grant <= N_REQ'(1) << w_sel_idx;
                        r_gidx  <= w_sel_idx;
                        r_mul_a <= i_req_a[w_sel_idx*WIDTH +: WIDTH];
                        r_mul_b <= i_req_b[w_sel_idx*WIDTH +: WIDTH];
                        r_mul_n <= i_req_n[w_sel_idx*WIDTH +: WIDTH];
                    end
                end
                S_WAIT: begin
                    if (i_mul_done) begin
                        r_result <= i_mul_result;
                    end else if (w_timeout) begin
                        // Abandoned transaction: release the grant and move past the owner
                        r_grant <= '0;
                        r_ptr   <= w_ptr_nxt;
                    end
                end
                S_RESP: begin
                    r_grant <= '0;
                    r_ptr   <= w_ptr_nxt;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MONT_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_error;

    // Last permitted S_WAIT cycle has been reached without a completion
    assign w_timeout = (r_state == S_WAIT) && (r_wd_cnt == WD_W'(TIMEOUT - 1));

    // Watchdog counter: cleared on the way into S_WAIT, counts every S_WAIT cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

    // One-cycle error pulse coinciding with the return to S_IDLE
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_error <= 1'b0;
        end else begin
            r_error <= w_timeout && !i_mul_done;
        end
    end

    assign o_error = r_error;
`else
    assign w_timeout = 1'b0;
`endif

    assign o_grant  = r_grant;
    assign o_result = r_result;
    assign o_mul_a  = r_mul_a;
    assign o_mul_b  = r_mul_b;
    assign o_mul_n  = r_mul_n;

endmodule
`default_nettype wire

// File: tb/tb_mont_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mont_mul_arbiter
//  Description : Directed self-checking bench for mont_mul_arbiter with a
//                small behavioural multiplier (fixed 5-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mont_mul_arbiter;

    localparam int N_REQ   = 2;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 8;
    localparam int MUL_LAT = 5;

    logic                   i_clk = 1'b0;
    logic                   i_rst = 1'b0;
    logic [N_REQ-1:0]       i_req = '0;
    logic [N_REQ*WIDTH-1:0] i_req_a = '0;
    logic [N_REQ*WIDTH-1:0] i_req_b = '0;
    logic [N_REQ*WIDTH-1:0] i_req_n = '0;
    logic [N_REQ-1:0]       o_grant;
    logic [N_REQ-1:0]       o_done;
    logic [WIDTH-1:0]       o_result;
    logic                   o_busy;
    logic                   o_mul_start;
    logic [WIDTH-1:0]       o_mul_a;
    logic [WIDTH-1:0]       o_mul_b;
    logic [WIDTH-1:0]       o_mul_n;
    logic                   i_mul_done = 1'b0;
    logic [WIDTH-1:0]       i_mul_result = '0;
`ifdef MONT_ARB_TIMEOUT_EN
    logic                   o_error;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural multiplier state
    int   mul_rem   = 0;
    logic model_en  = 1'b1;
    logic fixed_res = 1'b1;

    mont_mul_arbiter #(
        .N_REQ   (N_REQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .i_req_a      (i_req_a),
        .i_req_b      (i_req_b),
        .i_req_n      (i_req_n),
        .o_grant      (o_grant),
        .o_done       (o_done),
        .o_result     (o_result),
        .o_busy       (o_busy),
        .o_mul_start  (o_mul_start),
        .o_mul_a      (o_mul_a),
        .o_mul_b      (o_mul_b),
        .o_mul_n      (o_mul_n),
        .i_mul_done   (i_mul_done),
        .i_mul_result (i_mul_result)
`ifdef MONT_ARB_TIMEOUT_EN
        ,
        .o_error      (o_error)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one cycle; settle 1 time unit after the edge, then run the multiplier model
    task automatic tick();
        @(posedge i_clk);
        #1;
        i_mul_done = 1'b0;
        if (model_en) begin
            if (mul_rem > 0) begin
                mul_rem--;
                if (mul_rem == 0) begin
                    i_mul_done   = 1'b1;
                    i_mul_result = fixed_res ? 32'h1234 : (o_mul_a * o_mul_b + o_mul_n);
                end
            end
            if (o_mul_start) mul_rem = MUL_LAT;
        end
    endtask

    task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b, input logic [31:0] n);
        i_req_a[k*WIDTH +: WIDTH] = a;
        i_req_b[k*WIDTH +: WIDTH] = b;
        i_req_n[k*WIDTH +: WIDTH] = n;
    endtask

    logic [1:0]  exp_g [3] = '{2'b01, 2'b10, 2'b01};
    logic [31:0] exp_r [3] = '{32'd160, 32'd466, 32'd160};

    initial begin
        // ---------------- reset with requests pending ----------------
        i_req = 2'b11;
        set_ops(0, 32'd9, 32'd9, 32'd9);
        set_ops(1, 32'd8, 32'd8, 32'd8);
        repeat (3) tick();
        check_eq("rst_grant", o_grant, 2'b00);
        check_eq("rst_busy", o_busy, 1'b0);
        check_eq("rst_start", o_mul_start, 1'b0);
        check_eq("rst_done", o_done, 2'b00);
        check_eq("rst_result", o_result, 32'h0);
        check_eq("rst_mul_abn", {o_mul_a, o_mul_b, o_mul_n}, 96'h0);
        i_req = 2'b00;
        i_rst = 1'b1;
        tick();

        // ---------------- single requester, fixed 32'h1234 result ----------------
        set_ops(0, 32'd3, 32'd5, 32'd7);
        i_req = 2'b01;                        // cycle 0
        tick();                               // cycle 1
        check_eq("s1_grant", o_grant, 2'b01);
        check_eq("s1_start", o_mul_start, 1'b1);
        check_eq("s1_busy", o_busy, 1'b1);
        check_eq("s1_ops", {o_mul_a, o_mul_b, o_mul_n}, {32'd3, 32'd5, 32'd7});
        tick();                               // cycle 2
        check_eq("s1_start_once", o_mul_start, 1'b0);
        repeat (4) tick();                    // cycle 6
        check_eq("s1_done_early", o_done, 2'b00);
        tick();                               // cycle 7
        check_eq("s1_done", o_done, 2'b01);
        check_eq("s1_result", o_result, 32'h1234);
        i_req = 2'b00;
        tick();                               // cycle 8
        check_eq("s1_idle_busy", o_busy, 1'b0);
        check_eq("s1_idle_grant", o_grant, 2'b00);
        check_eq("s1_idle_done", o_done, 2'b00);

        // ---------------- simultaneous requests, pointer reset to 0 ----------------
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        fixed_res = 1'b0;
        set_ops(0, 32'd11, 32'd13, 32'd17);   // 11*13+17 = 160
        set_ops(1, 32'd19, 32'd23, 32'd29);   // 19*23+29 = 466
        i_req = 2'b11;
        for (int t = 0; t < 3; t++) begin
            int starts;
            int cyc;
            starts = 0;
            cyc    = 0;
            while (o_done == 2'b00 && cyc < 20) begin
                tick();
                cyc++;
                if (o_mul_start) begin
                    starts++;
                    check_eq($sformatf("rr%0d_grant", t), o_grant, exp_g[t]);
                end
            end
            if (cyc >= 20) check_eq($sformatf("rr%0d_no_done", t), 1'b0, 1'b1);
            check_eq($sformatf("rr%0d_done", t), o_done, exp_g[t]);
            check_eq($sformatf("rr%0d_result", t), o_result, exp_r[t]);
            check_eq($sformatf("rr%0d_starts", t), starts, 1);
            if (t == 2) i_req = 2'b00;
            tick();
        end

        // ---------------- operand stability during S_WAIT ----------------
        set_ops(0, 32'd100, 32'd3, 32'd1);    // 100*3+1 = 301
        i_req = 2'b01;
        tick();                               // ISSUE
        check_eq("stab_grant", o_grant, 2'b01);
        tick();                               // WAIT
        i_req_a[0 +: WIDTH] = 32'd555;
        tick();
        check_eq("stab_mul_a", o_mul_a, 32'd100);
        begin
            int cyc;
            cyc = 0;
            while (o_done == 2'b00 && cyc < 20) begin
                tick();
                cyc++;
            end
            if (cyc >= 20) check_eq("stab_no_done", 1'b0, 1'b1);
        end
        check_eq("stab_done", o_done, 2'b01);
        check_eq("stab_result", o_result, 32'd301);
        i_req = 2'b00;
        tick();

        // ---------------- spurious i_mul_done in S_IDLE and S_ISSUE ----------------
        model_en = 1'b0;
        i_mul_done   = 1'b1;
        i_mul_result = 32'hDEAD;
        tick();
        check_eq("spur_idle_done", o_done, 2'b00);
        check_eq("spur_idle_busy", o_busy, 1'b0);
        set_ops(1, 32'd2, 32'd4, 32'd6);
        i_req = 2'b10;
        tick();                               // ISSUE
        check_eq("spur_grant", o_grant, 2'b10);
        i_mul_done   = 1'b1;
        i_mul_result = 32'hBEEF;
        tick();                               // WAIT
        check_eq("spur_wait_done", o_done, 2'b00);
        check_eq("spur_wait_busy", o_busy, 1'b1);
        check_eq("spur_result_hold", o_result, 32'd301);
        tick();
        tick();
        check_eq("spur_still_wait", o_busy, 1'b1);
        i_mul_done   = 1'b1;
        i_mul_result = 32'h00AA;
        tick();                               // RESP
        check_eq("spur_done", o_done, 2'b10);
        check_eq("spur_result", o_result, 32'h00AA);
        i_req = 2'b00;
        tick();
        check_eq("spur_idle", o_busy, 1'b0);

`ifdef MONT_ARB_TIMEOUT_EN
        // ---------------- watchdog: multiplier never answers ----------------
        set_ops(0, 32'd1, 32'd1, 32'd1);
        i_req = 2'b01;
        tick();                               // cycle 1: ISSUE
        check_eq("to_grant0", o_grant, 2'b01);
        i_req = 2'b11;
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();                           // cycles 2..9: WAIT
            check_eq($sformatf("to_no_err_%0d", i), o_error, 1'b0);
        end
        tick();                               // cycle 10
        check_eq("to_error", o_error, 1'b1);
        check_eq("to_done", o_done, 2'b00);
        check_eq("to_busy", o_busy, 1'b0);
        check_eq("to_result", o_result, 32'h00AA);
        tick();                               // cycle 11
        check_eq("to_error_pulse", o_error, 1'b0);
        check_eq("to_next_grant", o_grant, 2'b10);
        i_req = 2'b00;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
